// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg : shared types and constants for the SPI register bank
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int   FRAME_BITS = 16;
  localparam logic RW_WRITE   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge : STAGES-deep pin synchroniser with rising/falling detect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES  = 2,   // must be >= 2
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank : SPI mode-0 write target owning the PWM control registers.
// Optional read-back on cipo when SPI_READBACK_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [4:0] c_CNT_MAX  = 5'd17;
  localparam logic [4:0] c_CNT_FULL = 5'(FRAME_BITS);
  localparam logic [6:0] c_NUM_REGS = 7'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s,  ncs_rise,  ncs_fall;
  logic copi_s, copi_rise, copi_fall;
  logic unused_copi_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_copi_edges = copi_rise ^ copi_fall ^ sclk_s;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        pend_q,  pend_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic [6:0]  frame_addr;
  logic        frame_ok;

  function automatic logic [7:0] reg_rd(input logic [7:0] regs [NUM_REGS],
                                        input logic [6:0] addr);
    reg_rd = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 7'(i)) reg_rd = regs[i];
    end
  endfunction

  assign frame_addr = shreg_q[14:8];
  assign frame_ok   = (cnt_q == c_CNT_FULL) && (shreg_q[15] == RW_WRITE) &&
                      (frame_addr < c_NUM_REGS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    pend_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      ST_IDLE: begin
        // pend_q catches an ncs fall that landed in the single COMMIT cycle
        if (ncs_fall || pend_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise && !ncs_s) begin
          shreg_d = {shreg_q[14:0], copi_s};
          if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == 7'(i)) regs_d[i] = shreg_q[7:0];
          end
        end
        pend_d  = ncs_fall;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pend_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  assign en_reg_out_7_0  = reg_rd(regs_q, ADDR_EN_OUT_LO);
  assign en_reg_out_15_8 = reg_rd(regs_q, ADDR_EN_OUT_HI);
  assign en_reg_pwm_7_0  = reg_rd(regs_q, ADDR_EN_PWM_LO);
  assign en_reg_pwm_15_8 = reg_rd(regs_q, ADDR_EN_PWM_HI);
  assign pwm_duty_cycle  = reg_rd(regs_q, ADDR_DUTY);

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;

  // After 8 bits the shifter holds R/W+address; a read loads the data byte
  always_comb begin
    tx_d = tx_q;
    if (state_q == ST_IDLE) begin
      tx_d = '0;
    end else if (state_q == ST_SHIFT && sclk_fall && !ncs_s) begin
      if (cnt_q == 5'd8 && shreg_q[7] != RW_WRITE) begin
        tx_d = reg_rd(regs_q, shreg_q[6:0]);
      end else begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  assign cipo = ncs_s ? 1'b0 : tx_q[7];
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign cipo             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank : directed + randomized frames against a register model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_spi_reg_bank;

  localparam int SYNC = 2;
  localparam int NREG = 5;
  localparam int HALF = 4;   // SCLK = clk/8

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       copi  = 1'b0;
  logic       ncs   = 1'b1;
  logic       cipo;
  logic [7:0] r0, r1, r2, r3, r4;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model [NREG];
  logic [31:0] cap;

  always #5 clk = ~clk;

  spi_reg_bank #(.SYNC_STAGES(SYNC), .NUM_REGS(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] obs [NREG];
    obs[0] = r0; obs[1] = r1; obs[2] = r2; obs[3] = r3; obs[4] = r4;
    for (int i = 0; i < NREG; i++) check($sformatf("%s reg%0d", tag, i), obs[i], model[i]);
  endtask

  // Only a 16-bit write to an implemented address changes the bank
  function automatic void model_frame(input logic [31:0] bits, input int nbits);
    int a;
    a = int'(bits[14:8]);
    if (nbits == 16 && bits[15] && a < NREG) model[a] = bits[7:0];
  endfunction

  function automatic logic [7:0] model_read(input logic [31:0] bits);
    int a;
    a = int'(bits[14:8]);
`ifdef SPI_READBACK_EN
    return (a < NREG) ? model[a] : 8'h00;
`else
    return (a < 0) ? model[0] : 8'h00;
`endif
  endfunction

  task automatic spi_shift(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (HALF) @(negedge clk);
      cap  = {cap[30:0], cipo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int nbits, input int gap);
    cap = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_shift(bits, nbits);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic settle();
    repeat (SYNC + 4) @(negedge clk);
  endtask

  logic [31:0] f;
  logic [31:0] b2b [4];
  logic [7:0]  old_v, exp_v;
  int          len, sel;

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset cipo", {7'b0, cipo}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x8455 with exact commit latency
    f     = 32'h8455;
    old_v = model[4];
    model_frame(f, 16);
    cap = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_shift(f, 16);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency edge%0d", k), r4, (k < SYNC + 2) ? old_v : model[4]);
    end
    settle();
    check_regs("write 8455");

    // Error frames
    spi_frame(32'h8799, 16, 4);      settle(); model_frame(32'h8799, 16);  check_regs("bad addr");
    spi_frame(32'h8433 >> 1, 15, 4); settle(); model_frame(32'h4219, 15);  check_regs("short frame");
    spi_frame(32'h18466, 17, 4);     settle(); model_frame(32'h18466, 17); check_regs("long frame");

    // Back-to-back writes, 2-clk ncs gap
    b2b[0] = 32'h80FF; b2b[1] = 32'h81A5; b2b[2] = 32'h8203; b2b[3] = 32'h83C3;
    for (int i = 0; i < 4; i++) begin
      spi_frame(b2b[i], 16, 2);
      model_frame(b2b[i], 16);
    end
    settle();
    check_regs("back-to-back");

    // Reset in the middle of a frame
    cap = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_shift(32'h80FF >> 7, 9);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    spi_shift(32'h80FF, 7);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    settle();
    check_regs("mid-frame reset");
    spi_frame(32'h8011, 16, 4); settle(); model_frame(32'h8011, 16);
    check_regs("after reset");

    // Read-back
    spi_frame(32'h8242, 16, 4); settle(); model_frame(32'h8242, 16);
    spi_frame(32'h0200, 16, 4);
    check("readback 0x02", cap[7:0], model_read(32'h0200));
    settle();
    check_regs("after read");
    check("cipo idle", {7'b0, cipo}, 8'h00);

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      f   = {16'h0, 1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
      sel = int'($urandom_range(0, 9));
      len = 16;
      if (sel == 0) begin
        len = 15;
        f   = f >> 1;
      end else if (sel == 1) begin
        len = 17;
        f   = {15'h0, 1'($urandom_range(0, 1)), f[15:0]};
      end
      spi_frame(f, len, 2 + int'($urandom_range(0, 6)));
      if (len == 16 && !f[15]) begin
        exp_v = model_read(f);
        check($sformatf("rand read %04h", f[15:0]), cap[7:0], exp_v);
      end
      settle();
      model_frame(f, len);
      check_regs($sformatf("rand %0d frame %05h/%0d", n, f[16:0], len));
    end
    check("cipo final", {7'b0, cipo}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
